// File: rtl/operand_collector_if.sv
// Issue and dispatch channels of the operand collector.
// master = instruction source / execute side, slave = collector.
interface operand_collector_if #(
   parameter int DATA_W = 256,
   parameter int TAG_W  = 8
);
   logic              issue_valid;
   logic              issue_ready;
   logic [4:0]        issue_src0;
   logic [4:0]        issue_src1;
   logic              issue_src1_vld;
   logic [TAG_W-1:0]  issue_tag;
   logic              disp_valid;
   logic              disp_ready;
   logic [DATA_W-1:0] disp_src0;
   logic [DATA_W-1:0] disp_src1;
   logic [TAG_W-1:0]  disp_tag;

   modport master (
      output issue_valid, issue_src0, issue_src1,
      output issue_src1_vld, issue_tag, disp_ready,
      input  issue_ready, disp_valid, disp_src0,
      input  disp_src1, disp_tag
   );

   modport slave (
      input  issue_valid, issue_src0, issue_src1,
      input  issue_src1_vld, issue_tag, disp_ready,
      output issue_ready, disp_valid, disp_src0,
      output disp_src1, disp_tag
   );
endinterface

// File: rtl/operand_collector.sv
// Operand collector: parks issued instructions in slots, reads the
// 4-bank register file per operand and dispatches complete sets.
module operand_collector #(
   parameter int NUM_SLOTS = 4,
   parameter int DATA_W    = 256,
   parameter int TAG_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   operand_collector_if.slave io,
   input  logic              rf_wr_0,
   input  logic              rf_wr_1,
   input  logic              rf_wr_2,
   input  logic              rf_wr_3,
   output logic [2:0]        rf_addr_0,
   output logic [2:0]        rf_addr_1,
   output logic [2:0]        rf_addr_2,
   output logic [2:0]        rf_addr_3,
   output logic [2:0]        rf_ocid_0,
   output logic [2:0]        rf_ocid_1,
   output logic [2:0]        rf_ocid_2,
   output logic [2:0]        rf_ocid_3,
   input  logic [DATA_W-1:0] rf_data_0,
   input  logic [DATA_W-1:0] rf_data_1,
   input  logic [DATA_W-1:0] rf_data_2,
   input  logic [DATA_W-1:0] rf_data_3,
   input  logic [2:0]        rf_ocid_in_0,
   input  logic [2:0]        rf_ocid_in_1,
   input  logic [2:0]        rf_ocid_in_2,
   input  logic [2:0]        rf_ocid_in_3
);
   localparam int NT = 2 * NUM_SLOTS;

   typedef enum logic [1:0] {
      FREE, COLLECT, READY
   } slot_e;

   slot_e             st_q [NUM_SLOTS];
   slot_e             st_d [NUM_SLOTS];
   logic [4:0]        reg_q [NT];
   logic [DATA_W-1:0] data_q [NT];
   logic [TAG_W-1:0]  tag_q [NUM_SLOTS];
   logic [NT-1:0]     pend_q, pend_d;
   logic [NT-1:0]     capt_q, capt_d;
   logic [2:0]        rr_q [4];
   logic [2:0]        rr_d [4];
   logic [3:0]        infl_q;
   logic [1:0]        dptr_q;

   logic [3:0]        wr, gnt;
   logic [2:0]        addr [4];
   logic [2:0]        ocid [4];
   logic [2:0]        rocid [4];
   logic [DATA_W-1:0] rdata [4];
   logic [2:0]        aidx;
   logic [1:0]        islot, dsel, didx;
   logic              anyfree, ifire, dv, dfire;

   assign wr       = {rf_wr_3, rf_wr_2, rf_wr_1, rf_wr_0};
   assign rdata[0] = rf_data_0;
   assign rdata[1] = rf_data_1;
   assign rdata[2] = rf_data_2;
   assign rdata[3] = rf_data_3;
   assign rocid[0] = rf_ocid_in_0;
   assign rocid[1] = rf_ocid_in_1;
   assign rocid[2] = rf_ocid_in_2;
   assign rocid[3] = rf_ocid_in_3;
   assign rf_addr_0 = addr[0];
   assign rf_addr_1 = addr[1];
   assign rf_addr_2 = addr[2];
   assign rf_addr_3 = addr[3];
   assign rf_ocid_0 = ocid[0];
   assign rf_ocid_1 = ocid[1];
   assign rf_ocid_2 = ocid[2];
   assign rf_ocid_3 = ocid[3];

   // Scanning downwards leaves the lowest-index FREE slot selected.
   always_comb begin
      anyfree = 1'b0;
      islot   = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (st_q[s] == FREE) begin
            anyfree = 1'b1;
            islot   = 2'(s);
         end
      end
   end

   assign io.issue_ready = rst_n & anyfree;
   assign ifire = io.issue_valid & io.issue_ready;

   always_comb begin
      dv   = 1'b0;
      dsel = '0;
      didx = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         didx = dptr_q + 2'(i);
         if (!dv && st_q[didx] == READY) begin
            dv   = 1'b1;
            dsel = didx;
         end
      end
   end

   assign dfire         = dv & io.disp_ready;
   assign io.disp_valid = dv;
   assign io.disp_src0  = dv ? data_q[{dsel, 1'b0}] : '0;
   assign io.disp_src1  = dv ? data_q[{dsel, 1'b1}] : '0;
   assign io.disp_tag   = dv ? tag_q[dsel] : '0;

   // Per-bank round-robin over the eight {slot, op} tags.
   always_comb begin
      gnt  = '0;
      aidx = '0;
      for (int k = 0; k < 4; k++) begin
         addr[k] = '0;
         ocid[k] = '0;
         rr_d[k] = rr_q[k];
      end
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NT; i++) begin
            aidx = rr_q[k] + 3'(i);
            if (!wr[k] && !gnt[k] && pend_q[aidx] &&
                reg_q[aidx][1:0] == 2'(k)) begin
               gnt[k]  = 1'b1;
               ocid[k] = aidx;
               addr[k] = reg_q[aidx][4:2];
               rr_d[k] = aidx + 3'd1;
            end
         end
      end
   end

   always_comb begin
      pend_d = pend_q;
      capt_d = capt_q;
      for (int k = 0; k < 4; k++) begin
         if (gnt[k]) pend_d[ocid[k]] = 1'b0;
         if (infl_q[k]) capt_d[rocid[k]] = 1'b1;
      end
      if (ifire) begin
         pend_d[{islot, 1'b0}] = 1'b1;
         pend_d[{islot, 1'b1}] = io.issue_src1_vld;
         capt_d[{islot, 1'b0}] = 1'b0;
         capt_d[{islot, 1'b1}] = !io.issue_src1_vld;
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
         st_d[s] = st_q[s];
         unique case (st_q[s])
            FREE:
               if (ifire && islot == 2'(s)) st_d[s] = COLLECT;
            COLLECT:
               if (capt_d[2*s] && capt_d[2*s+1]) st_d[s] = READY;
            READY:
               if (dfire && dsel == 2'(s)) st_d[s] = FREE;
            default: st_d[s] = FREE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            st_q[s]  <= FREE;
            tag_q[s] <= '0;
         end
         for (int t = 0; t < NT; t++) begin
            reg_q[t]  <= '0;
            data_q[t] <= '0;
         end
         for (int k = 0; k < 4; k++) rr_q[k] <= '0;
         pend_q <= '0;
         capt_q <= '0;
         infl_q <= '0;
         dptr_q <= '0;
      end else begin
         st_q   <= st_d;
         pend_q <= pend_d;
         capt_q <= capt_d;
         rr_q   <= rr_d;
         infl_q <= gnt;
         if (dfire) dptr_q <= dsel + 2'd1;
         for (int k = 0; k < 4; k++) begin
            if (infl_q[k]) data_q[rocid[k]] <= rdata[k];
         end
         if (ifire) begin
            reg_q[{islot, 1'b0}]  <= io.issue_src0;
            reg_q[{islot, 1'b1}]  <= io.issue_src1;
            data_q[{islot, 1'b1}] <= '0;
            tag_q[islot]          <= io.issue_tag;
         end
      end
   end
endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a 1-cycle latency
// register-file bank model returning a per-register data pattern.
module tb_operand_collector;
   localparam int DW = 256;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   int            nchk = 0;
   int            nfail = 0;
   int            lat;
   logic [3:0]    rf_wr;
   logic [DW-1:0] rf_data [4];
   logic [2:0]    rf_ocid_in [4];
   logic [2:0]    rf_addr [4];
   logic [2:0]    rf_ocid [4];

   operand_collector_if #(.DATA_W(DW), .TAG_W(TW)) io ();

   always #5 clk = ~clk;

   operand_collector #(.NUM_SLOTS(4), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .io(io),
      .rf_wr_0(rf_wr[0]), .rf_wr_1(rf_wr[1]),
      .rf_wr_2(rf_wr[2]), .rf_wr_3(rf_wr[3]),
      .rf_addr_0(rf_addr[0]), .rf_addr_1(rf_addr[1]),
      .rf_addr_2(rf_addr[2]), .rf_addr_3(rf_addr[3]),
      .rf_ocid_0(rf_ocid[0]), .rf_ocid_1(rf_ocid[1]),
      .rf_ocid_2(rf_ocid[2]), .rf_ocid_3(rf_ocid[3]),
      .rf_data_0(rf_data[0]), .rf_data_1(rf_data[1]),
      .rf_data_2(rf_data[2]), .rf_data_3(rf_data[3]),
      .rf_ocid_in_0(rf_ocid_in[0]), .rf_ocid_in_1(rf_ocid_in[1]),
      .rf_ocid_in_2(rf_ocid_in[2]), .rf_ocid_in_3(rf_ocid_in[3])
   );

   function automatic logic [DW-1:0] word(input logic [4:0] r);
      return {8{32'hDA7A_0000 | 32'(r)}};
   endfunction

   // Bank k, row a holds register {a, k}; data and tag come back a cycle later.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         rf_data[k]    <= word({rf_addr[k], 2'(k)});
         rf_ocid_in[k] <= rf_ocid[k];
      end
   end

   task automatic drive_issue(input logic [4:0] s0, input logic [4:0] s1,
                              input logic v1, input logic [7:0] tg);
      io.issue_valid    = 1'b1;
      io.issue_src0     = s0;
      io.issue_src1     = s1;
      io.issue_src1_vld = v1;
      io.issue_tag      = tg;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rf_wr = '0;
      io.issue_valid = 1'b0;
      io.issue_src0 = '0;
      io.issue_src1 = '0;
      io.issue_src1_vld = 1'b0;
      io.issue_tag = '0;
      io.disp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nchk++; if (io.issue_ready !== 1'b0) begin nfail++; $display("FAIL reset_issue_ready got %0b exp 0", io.issue_ready); end
      nchk++; if (io.disp_valid !== 1'b0) begin nfail++; $display("FAIL reset_disp_valid got %0b exp 0", io.disp_valid); end
      nchk++; if (io.disp_tag !== 8'h00 || io.disp_src0 !== '0 || io.disp_src1 !== '0) begin nfail++; $display("FAIL reset_disp_data tag %h exp 00 (src words nonzero)", io.disp_tag); end
      for (int k = 0; k < 4; k++) begin
         nchk++; if (rf_addr[k] !== 3'd0 || rf_ocid[k] !== 3'd0) begin nfail++; $display("FAIL reset_bank%0d addr %0d ocid %0d exp 0 0", k, rf_addr[k], rf_ocid[k]); end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      nchk++; if (io.issue_ready !== 1'b1) begin nfail++; $display("FAIL post_reset_issue_ready got %0b exp 1", io.issue_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [DW-1:0] s0;
      drive_issue(5'd5, 5'd10, 1'b1, 8'h3C);
      @(negedge clk);
      nchk++; if (io.issue_ready !== 1'b1) begin nfail++; $display("FAIL basic_issue_ready got %0b exp 1", io.issue_ready); end
      @(posedge clk); #1 io.issue_valid = 1'b0;
      @(negedge clk);
      nchk++; if (rf_addr[1] !== 3'd1 || rf_ocid[1] !== 3'd0) begin nfail++; $display("FAIL basic_bank1 addr %0d ocid %0d exp 1 0", rf_addr[1], rf_ocid[1]); end
      nchk++; if (rf_addr[2] !== 3'd2 || rf_ocid[2] !== 3'd1) begin nfail++; $display("FAIL basic_bank2 addr %0d ocid %0d exp 2 1", rf_addr[2], rf_ocid[2]); end
      lat = 0;
      for (int i = 2; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (io.disp_valid) lat = i;
      end
      nchk++; if (lat !== 3) begin nfail++; $display("FAIL basic_latency got %0d exp 3", lat); end
      nchk++; if (io.disp_src0 !== word(5'd5)) begin nfail++; $display("FAIL basic_src0 got %h exp %h", io.disp_src0[31:0], 32'hDA7A0005); end
      nchk++; if (io.disp_src1 !== word(5'd10)) begin nfail++; $display("FAIL basic_src1 got %h exp %h", io.disp_src1[31:0], 32'hDA7A000A); end
      nchk++; if (io.disp_tag !== 8'h3C) begin nfail++; $display("FAIL basic_tag got %h exp 3c", io.disp_tag); end
      s0 = io.disp_src0;
      @(posedge clk); #1;
      @(negedge clk);
      nchk++; if (io.disp_valid !== 1'b1 || io.disp_tag !== 8'h3C || io.disp_src0 !== s0) begin nfail++; $display("FAIL basic_hold valid %0b tag %h exp 1 3c", io.disp_valid, io.disp_tag); end
      io.disp_ready = 1'b1;
      @(posedge clk); #1 io.disp_ready = 1'b0;
      @(negedge clk);
      nchk++; if (io.disp_valid !== 1'b0) begin nfail++; $display("FAIL basic_after_disp valid %0b exp 0", io.disp_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_same_bank();
      drive_issue(5'd4, 5'd8, 1'b1, 8'h5A);
      @(posedge clk); #1 io.issue_valid = 1'b0;
      @(negedge clk);
      nchk++; if (rf_addr[0] !== 3'd1 || rf_ocid[0] !== 3'd0) begin nfail++; $display("FAIL samebank_grant1 addr %0d ocid %0d exp 1 0", rf_addr[0], rf_ocid[0]); end
      @(negedge clk);
      nchk++; if (rf_addr[0] !== 3'd2 || rf_ocid[0] !== 3'd1) begin nfail++; $display("FAIL samebank_grant2 addr %0d ocid %0d exp 2 1", rf_addr[0], rf_ocid[0]); end
      lat = 0;
      for (int i = 3; i <= 12 && lat == 0; i++) begin
         @(negedge clk);
         if (io.disp_valid) lat = i;
      end
      nchk++; if (lat !== 4) begin nfail++; $display("FAIL samebank_latency got %0d exp 4", lat); end
      nchk++; if (io.disp_src0 !== word(5'd4) || io.disp_src1 !== word(5'd8)) begin nfail++; $display("FAIL samebank_data src0 %h src1 %h exp da7a0004 da7a0008", io.disp_src0[31:0], io.disp_src1[31:0]); end
      io.disp_ready = 1'b1;
      @(posedge clk); #1 io.disp_ready = 1'b0;
   endtask

   task automatic test_wr_stall();
      drive_issue(5'd0, 5'd0, 1'b0, 8'h77);
      rf_wr[0] = 1'b1;
      @(posedge clk); #1 io.issue_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         @(negedge clk);
         if (io.disp_valid) lat = i;
         if (i == 3) begin
            @(posedge clk); #1 rf_wr[0] = 1'b0;
         end
      end
      nchk++; if (lat !== 6) begin nfail++; $display("FAIL wrstall_latency got %0d exp 6", lat); end
      nchk++; if (io.disp_src0 !== word(5'd0) || io.disp_src1 !== '0) begin nfail++; $display("FAIL wrstall_data src0 %h src1 %h exp da7a0000 0", io.disp_src0[31:0], io.disp_src1[31:0]); end
      io.disp_ready = 1'b1;
      @(posedge clk); #1 io.disp_ready = 1'b0;
   endtask

   task automatic test_single_op();
      drive_issue(5'd31, 5'd7, 1'b0, 8'hC1);
      @(posedge clk); #1 io.issue_valid = 1'b0;
      @(negedge clk);
      nchk++; if (rf_addr[3] !== 3'd7 || rf_ocid[3] !== 3'd0) begin nfail++; $display("FAIL single_grant addr %0d ocid %0d exp 7 0", rf_addr[3], rf_ocid[3]); end
      @(negedge clk);
      nchk++; if (rf_addr[3] !== 3'd0 || rf_ocid[3] !== 3'd0) begin nfail++; $display("FAIL single_no_second_read addr %0d ocid %0d exp 0 0", rf_addr[3], rf_ocid[3]); end
      @(negedge clk);
      nchk++; if (io.disp_valid !== 1'b1) begin nfail++; $display("FAIL single_valid got %0b exp 1", io.disp_valid); end
      nchk++; if (io.disp_src0 !== word(5'd31) || io.disp_src1 !== '0 || io.disp_tag !== 8'hC1) begin nfail++; $display("FAIL single_data src0 %h src1 %h tag %h exp da7a001f 0 c1", io.disp_src0[31:0], io.disp_src1[31:0], io.disp_tag); end
      io.disp_ready = 1'b1;
      @(posedge clk); #1 io.disp_ready = 1'b0;
   endtask

   task automatic test_midop_reset();
      drive_issue(5'd5, 5'd10, 1'b1, 8'h99);
      @(posedge clk); #1 io.issue_valid = 1'b0;
      @(negedge clk);
      nchk++; if (rf_addr[1] !== 3'd1) begin nfail++; $display("FAIL midrst_grant addr %0d exp 1", rf_addr[1]); end
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      nchk++; if (io.issue_ready !== 1'b0 || io.disp_valid !== 1'b0) begin nfail++; $display("FAIL midrst_in_reset ready %0b valid %0b exp 0 0", io.issue_ready, io.disp_valid); end
      nchk++; if (rf_addr[1] !== 3'd0 || rf_addr[2] !== 3'd0 || rf_ocid[2] !== 3'd0) begin nfail++; $display("FAIL midrst_bank_out a1 %0d a2 %0d o2 %0d exp 0 0 0", rf_addr[1], rf_addr[2], rf_ocid[2]); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nchk++; if (io.disp_valid !== 1'b0 || io.issue_ready !== 1'b1) begin nfail++; $display("FAIL midrst_idle%0d valid %0b ready %0b exp 0 1", i, io.disp_valid, io.issue_ready); end
         nchk++; if (rf_addr[1] !== 3'd0 || rf_addr[2] !== 3'd0) begin nfail++; $display("FAIL midrst_regrant%0d a1 %0d a2 %0d exp 0 0", i, rf_addr[1], rf_addr[2]); end
      end
      @(posedge clk); #1;
      drive_issue(5'd1, 5'd2, 1'b1, 8'h42);
      @(posedge clk); #1 io.issue_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (io.disp_valid) lat = i;
      end
      nchk++; if (lat !== 3 || io.disp_tag !== 8'h42) begin nfail++; $display("FAIL midrst_reissue latency %0d tag %h exp 3 42", lat, io.disp_tag); end
      io.disp_ready = 1'b1;
      @(posedge clk); #1 io.disp_ready = 1'b0;
   endtask

   task automatic test_fill();
      rst_n = 1'b0;
      io.disp_ready = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_issue(5'(4 * i + 1), 5'(4 * i + 2), 1'b1, 8'(8'h10 + i));
         @(negedge clk);
         nchk++; if (io.issue_ready !== (i < 4)) begin nfail++; $display("FAIL fill_ready%0d got %0b exp %0b", i, io.issue_ready, (i < 4)); end
         if (i < 4) begin
            @(posedge clk); #1;
         end
      end
      repeat (8) begin
         @(posedge clk); #1;
      end
      io.disp_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         nchk++; if (io.disp_valid !== 1'b1 || io.disp_tag !== 8'(8'h10 + j)) begin nfail++; $display("FAIL fill_order%0d valid %0b tag %h exp 1 %h", j, io.disp_valid, io.disp_tag, 8'(8'h10 + j)); end
         nchk++; if (io.disp_src0 !== word(5'(4 * j + 1))) begin nfail++; $display("FAIL fill_src0_%0d got %h exp %h", j, io.disp_src0[31:0], 32'hDA7A0000 | 32'(4 * j + 1)); end
         if (j == 0) begin
            nchk++; if (io.issue_ready !== 1'b0) begin nfail++; $display("FAIL fill_ready_same_cycle got %0b exp 0", io.issue_ready); end
         end
         if (j == 1) begin
            nchk++; if (io.issue_ready !== 1'b1) begin nfail++; $display("FAIL fill_ready_next_cycle got %0b exp 1", io.issue_ready); end
         end
         if (j == 2) begin
            nchk++; if (rf_addr[1] !== 3'd4 || rf_ocid[1] !== 3'd0) begin nfail++; $display("FAIL fill_5th_slot addr %0d ocid %0d exp 4 0", rf_addr[1], rf_ocid[1]); end
         end
         @(posedge clk); #1;
         if (j == 1) io.issue_valid = 1'b0;
      end
      lat = 0;
      for (int i = 0; i < 6 && lat == 0; i++) begin
         @(negedge clk);
         if (io.disp_valid) lat = 1;
      end
      nchk++; if (lat !== 1 || io.disp_tag !== 8'h14) begin nfail++; $display("FAIL fill_5th_disp seen %0d tag %h exp 1 14", lat, io.disp_tag); end
      nchk++; if (io.disp_src0 !== word(5'd17) || io.disp_src1 !== word(5'd18)) begin nfail++; $display("FAIL fill_5th_data src0 %h src1 %h exp da7a0011 da7a0012", io.disp_src0[31:0], io.disp_src1[31:0]); end
      @(posedge clk); #1 io.disp_ready = 1'b0;
      @(negedge clk);
      nchk++; if (io.disp_valid !== 1'b0) begin nfail++; $display("FAIL fill_drained valid %0b exp 0", io.disp_valid); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_same_bank();
      test_wr_stall();
      test_single_op();
      test_midop_reset();
      test_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
